// File: rtl/pr3_pkg.sv
// Shared definitions for the pr3 MIPS datapath front end.
// Ports: none (package only).
// Holds the datapath word width, the default reset PC and the fetch FSM state type.
package pr3_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifetch_state_t;

endpackage : pr3_pkg

// File: rtl/next_pc_sel.sv
// Purpose: combinational priority mux for the next program counter.
// Ports: current pc, jump/branch requests with targets, sequential-advance flag -> next pc.
// Priority is jump > branch > sequential (pc+4) > hold. Redirect targets are word aligned.
module next_pc_sel
  import pr3_pkg::*;
(
  input  logic [WORD_W-1:0] pc_i,
  input  logic              jump_i,
  input  logic [WORD_W-1:0] jump_target_i,
  input  logic              branch_taken_i,
  input  logic [WORD_W-1:0] branch_target_i,
  input  logic              advance_i,
  output logic [WORD_W-1:0] next_pc_o
);

  // Clearing the low two bits keeps every fetch address on a word boundary,
  // so a sloppy target from downstream can never produce a split word.
  localparam logic [WORD_W-1:0] ALIGN_MASK = ~(WORD_W'(3));

  always_comb begin
    next_pc_o = pc_i;
    if (jump_i) begin
      next_pc_o = jump_target_i & ALIGN_MASK;
    end else if (branch_taken_i) begin
      next_pc_o = branch_target_i & ALIGN_MASK;
    end else if (advance_i) begin
      next_pc_o = pc_i + WORD_W'(4);
    end
  end

endmodule : next_pc_sel

// File: rtl/ifetch_unit.sv
// Purpose: pr3 instruction fetch stage; owns the PC and instruction memory and
//   presents one registered instruction per cycle over a valid/ready handshake.
// Ports: clk/rst (sync, active high); dec_ready from decode; branch/jump redirects
//   with byte targets; instr, instr_pc, pc_plus4, instr_valid, halted, fetch_count out.
module ifetch_unit
  import pr3_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 128,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_ready,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_target,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              instr_valid,
  output logic              halted,
  output logic [WORD_W-1:0] fetch_count
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);

  // Program storage; contents are loaded hierarchically from outside this module.
  logic [WORD_W-1:0] iMem [0:IMEM_DEPTH-1];

  ifetch_state_t     state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] instr_pc_q, instr_pc_d;
  logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;
  logic [WORD_W-1:0] fetch_count_q, fetch_count_d;

  logic              redirect;
  logic              handshake;
  logic              stall;
  logic              pc_out_of_range;
  logic              fetch_ok;
  logic [IDX_W-1:0]  imem_idx;
  logic [WORD_W-1:0] next_pc;

  assign redirect        = jump | branch_taken;
  assign handshake       = instr_valid_q & dec_ready;
  assign stall           = instr_valid_q & ~dec_ready;
  // Compare the full word address, so any PC beyond the array (including
  // wrapped high addresses) is caught rather than aliasing into memory.
  assign pc_out_of_range = (pc_q >> 2) >= WORD_W'(IMEM_DEPTH);
  assign fetch_ok        = (state_q == RUN) & ~redirect & ~stall & ~pc_out_of_range;
  assign imem_idx        = pc_q[IDX_W+1:2];

  next_pc_sel u_next_pc_sel (
    .pc_i            (pc_q),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .advance_i       (fetch_ok),
    .next_pc_o       (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_plus4_d    = pc_plus4_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    // A handshake completes whenever a valid word meets a ready decoder,
    // even if a redirect squashes the successor in the same cycle.
    fetch_count_d = fetch_count_q + WORD_W'(handshake);

    unique case (state_q)
      IDLE: begin
        // Single bubble after reset before the first fetch.
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Squash the sequential successor; no delay slot.
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything while decode is busy.
        end else if (pc_out_of_range) begin
          state_d       = HALT;
          instr_valid_d = 1'b0;
          halted_d      = 1'b1;
        end else begin
          instr_d       = iMem[imem_idx];
          instr_pc_d    = pc_q;
          pc_plus4_d    = pc_q + WORD_W'(4);
          instr_valid_d = 1'b1;
          pc_d          = next_pc;
        end
      end
      HALT: begin
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      pc_plus4_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule : ifetch_unit

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: sequential fetch, stall, branch, jump-over-branch,
// end-of-memory halt and reset from stall/halt, with hand-computed expectations.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  ifetch_unit #(
    .IMEM_DEPTH (128),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_ready     (dec_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Filler words for addresses beyond the test program: tag plus word index.
  function automatic logic [31:0] fill_word(input int idx);
    return 32'hA500_0000 | 32'(idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
    chk({tag, "_count"}, fetch_count, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_pc"}, instr_pc, 32'd0);
    chk({tag, "_pc4"}, pc_plus4, 32'd0);
  endtask

  // Reset for one edge, release; leaves the DUT in IDLE about to take its bubble.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    dec_ready     = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    jump          = 1'b0;
    jump_target   = 32'd0;
    for (int i = 0; i < 128; i++) dut.iMem[i] = fill_word(i);
    dut.iMem[0] = 32'h20080001;
    dut.iMem[1] = 32'h20090002;
    dut.iMem[2] = 32'h01095020;
    dut.iMem[3] = 32'hAC0A0000;

    // ---------------- sequential run ----------------
    step();
    do_reset();
    check_reset_state("rst0");
    step();
    chk("seq_bubble", {31'b0, instr_valid}, 32'd0);
    step();
    chk("seq_v0", {31'b0, instr_valid}, 32'd1);
    chk("seq_i0", instr, 32'h20080001);
    chk("seq_pc0", instr_pc, 32'h0);
    chk("seq_pc4_0", pc_plus4, 32'h4);
    step();
    chk("seq_i1", instr, 32'h20090002);
    chk("seq_pc1", instr_pc, 32'h4);
    chk("seq_cnt1", fetch_count, 32'd1);
    step();
    chk("seq_i2", instr, 32'h01095020);
    chk("seq_pc2", instr_pc, 32'h8);
    step();
    chk("seq_i3", instr, 32'hAC0A0000);
    chk("seq_pc3", instr_pc, 32'hC);
    chk("seq_cnt3", fetch_count, 32'd3);
    step();
    chk("seq_cnt4", fetch_count, 32'd4);
    chk("seq_pc_next", instr_pc, 32'h10);

    // ---------------- stall at instr_pc=8 ----------------
    do_reset();
    step();   // bubble
    step();   // pc 0
    step();   // pc 4
    step();   // pc 8 presented, count 2
    chk("stl_pre_pc", instr_pc, 32'h8);
    dec_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stl_instr", instr, 32'h01095020);
      chk("stl_pc", instr_pc, 32'h8);
      chk("stl_pc4", pc_plus4, 32'hC);
      chk("stl_valid", {31'b0, instr_valid}, 32'd1);
      chk("stl_cnt", fetch_count, 32'd2);
    end
    dec_ready = 1'b1;
    step();
    chk("stl_post_pc", instr_pc, 32'hC);
    chk("stl_post_instr", instr, 32'hAC0A0000);
    chk("stl_post_cnt", fetch_count, 32'd3);

    // ---------------- branch redirect ----------------
    do_reset();
    step();   // bubble
    step();   // pc 0
    step();   // pc 4
    chk("br_pre_pc", instr_pc, 32'h4);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken  = 1'b0;
    chk("br_squash", {31'b0, instr_valid}, 32'd0);
    chk("br_cnt", fetch_count, 32'd2);
    step();
    chk("br_valid", {31'b0, instr_valid}, 32'd1);
    chk("br_pc", instr_pc, 32'h40);
    chk("br_instr", instr, fill_word(16));
    chk("br_pc4", pc_plus4, 32'h44);

    // ---------------- jump over branch, misaligned, while stalled ----------------
    dec_ready     = 1'b0;
    jump          = 1'b1;
    jump_target   = 32'h23;
    branch_taken  = 1'b1;
    branch_target = 32'h8;
    step();
    jump         = 1'b0;
    branch_taken = 1'b0;
    dec_ready    = 1'b1;
    chk("jmp_squash", {31'b0, instr_valid}, 32'd0);
    chk("jmp_cnt", fetch_count, 32'd2);
    step();
    chk("jmp_pc", instr_pc, 32'h20);
    chk("jmp_instr", instr, fill_word(8));

    // ---------------- end of memory ----------------
    jump        = 1'b1;
    jump_target = 32'h1FC;
    step();
    jump = 1'b0;
    chk("eom_cnt_a", fetch_count, 32'd3);
    step();
    chk("eom_pc", instr_pc, 32'h1FC);
    chk("eom_instr", instr, fill_word(127));
    chk("eom_valid", {31'b0, instr_valid}, 32'd1);
    step();
    chk("eom_halted", {31'b0, halted}, 32'd1);
    chk("eom_invalid", {31'b0, instr_valid}, 32'd0);
    chk("eom_cnt_b", fetch_count, 32'd4);
    for (int c = 0; c < 50; c++) begin
      dec_ready     = 1'($urandom_range(0, 1));
      jump          = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      jump_target   = 32'h10;
      branch_target = 32'h20;
      step();
      chk("halt_hold_h", {31'b0, halted}, 32'd1);
      chk("halt_hold_v", {31'b0, instr_valid}, 32'd0);
      chk("halt_hold_cnt", fetch_count, 32'd4);
    end
    jump         = 1'b0;
    branch_taken = 1'b0;
    dec_ready    = 1'b1;

    // ---------------- reset while halted ----------------
    do_reset();
    check_reset_state("rst_halt");
    step();
    chk("rh_bubble", {31'b0, instr_valid}, 32'd0);
    step();
    chk("rh_pc", instr_pc, 32'h0);
    chk("rh_instr", instr, 32'h20080001);
    chk("rh_valid", {31'b0, instr_valid}, 32'd1);

    // ---------------- reset during a stall ----------------
    step();   // pc 4 presented
    dec_ready = 1'b0;
    step();   // stalled
    chk("rs_stall_pc", instr_pc, 32'h4);
    do_reset();
    check_reset_state("rst_stall");
    step();
    chk("rs_bubble", {31'b0, instr_valid}, 32'd0);
    step();
    chk("rs_valid", {31'b0, instr_valid}, 32'd1);
    chk("rs_pc", instr_pc, 32'h0);
    chk("rs_instr", instr, 32'h20080001);
    chk("rs_cnt", fetch_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ifetch_unit
